// File: rtl/booth_mult_arbiter_if.sv
// Handshake bundle between the systolic cells, the arbiter and the shared
// Booth core: request/grant, operand issue and product return.
interface booth_mult_arbiter_if #(
  parameter int WORDLENGTH = 16,
  parameter int IDW        = 2
);
  localparam int NREQ = 1 << IDW;

  logic [NREQ-1:0]            req;
  logic [NREQ*WORDLENGTH-1:0] mcand;
  logic [NREQ*WORDLENGTH-1:0] mplier;
  logic [NREQ-1:0]            gnt;
  logic                       busy;
  logic                       mul_start;
  logic [WORDLENGTH-1:0]      mul_a;
  logic [WORDLENGTH-1:0]      mul_b;
  logic                       mul_done;
  logic [2*WORDLENGTH-1:0]    mul_prod;
  logic [2*WORDLENGTH-1:0]    prod;
  logic                       prod_valid;
  logic [IDW-1:0]             prod_id;
  logic                       err;

  modport slave (
    input  req, mcand, mplier, mul_done, mul_prod,
    output gnt, busy, mul_start, mul_a, mul_b,
    output prod, prod_valid, prod_id, err
  );

  modport master (
    output req, mcand, mplier, mul_done, mul_prod,
    input  gnt, busy, mul_start, mul_a, mul_b,
    input  prod, prod_valid, prod_id, err
  );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin sharing of one sequential Booth multiplier among NREQ cells.
// Ports: wClk, reset (sync, active-high), bus (slave side of the bundle).
module booth_mult_arbiter #(
  parameter int WORDLENGTH = 16,
  parameter int IDW        = 2,
  parameter int TIMEOUT    = 64
) (
  input logic               wClk,
  input logic               reset,
  booth_mult_arbiter_if.slave bus
);
  localparam int NREQ = 1 << IDW;
  localparam int TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cur_id;
  logic [TW-1:0]  timer;

  logic           win_v;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;

  // Scan starting at ptr; IDW-bit addition wraps mod NREQ.
  always_comb begin
    win_v = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + IDW'(k);
      if (!win_v && bus.req[idx]) begin
        win_v = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge wClk) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      cur_id         <= '0;
      timer          <= '0;
      bus.gnt        <= '0;
      bus.busy       <= 1'b0;
      bus.mul_start  <= 1'b0;
      bus.mul_a      <= '0;
      bus.mul_b      <= '0;
      bus.prod       <= '0;
      bus.prod_valid <= 1'b0;
      bus.prod_id    <= '0;
      bus.err        <= 1'b0;
    end else begin
      bus.gnt        <= '0;
      bus.mul_start  <= 1'b0;
      bus.prod_valid <= 1'b0;
      bus.err        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_v) begin
            bus.gnt       <= NREQ'(1) << win;
            bus.mul_a     <= bus.mcand[int'(win)*WORDLENGTH +: WORDLENGTH];
            bus.mul_b     <= bus.mplier[int'(win)*WORDLENGTH +: WORDLENGTH];
            bus.mul_start <= 1'b1;
            bus.busy      <= 1'b1;
            cur_id        <= win;
            ptr           <= win + IDW'(1);
            timer         <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          timer <= timer + TW'(1);
          // Completion beats the watchdog when both land together.
          if (bus.mul_done) begin
            bus.prod       <= bus.mul_prod;
            bus.prod_id    <= cur_id;
            bus.prod_valid <= 1'b1;
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end else if (timer == TLAST) begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
